// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline types and constants.
// Used by the hazard controller and its helpers.
package otter_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_ERR_FLUSH
  } hz_state_t;

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module otter_sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         INC,
  output logic [W-1:0] CNT
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER hazard controller: load-use, redirect and memory-wait sequencing.
// Drives stage enables/flushes and keeps stall/flush counters.
module otter_hazard_ctrl #(
  parameter int REG_ADDR_W  = otter_pipe_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_RS1_USED,
  input  logic                  ID_RS2_USED,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MEMREAD,
  input  logic                  EX_BR_TAKEN,
  input  logic                  MEM_REQ,
  input  logic                  MEM_ACK,
  output logic                  PC_WE,
  output logic                  IF_ID_WE,
  output logic                  ID_EX_WE,
  output logic                  EX_MEM_WE,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_FLUSH,
  output logic                  MEM_WB_FLUSH,
  output logic                  MEM_ERR,
  output logic [PERF_W-1:0]     STALL_CNT,
  output logic [PERF_W-1:0]     FLUSH_CNT
);

  import otter_pipe_pkg::*;

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [REG_ADDR_W-1:0] RD_X0 = REG_ADDR_W'(REG_X0);

  hz_state_t         state_q;
  hz_state_t         state_d;
  logic [WCNT_W-1:0] wait_q;
  logic [WCNT_W-1:0] wait_d;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign rs1_hit  = ID_RS1_USED && (EX_RD == ID_RS1);
  assign rs2_hit  = ID_RS2_USED && (EX_RD == ID_RS2);
  assign load_use = EX_MEMREAD && (EX_RD != RD_X0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    PC_WE        = 1'b1;
    IF_ID_WE     = 1'b1;
    ID_EX_WE     = 1'b1;
    EX_MEM_WE    = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    MEM_WB_FLUSH = 1'b0;
    MEM_ERR      = 1'b0;

    unique case (state_q)
      HZ_RUN: begin
        if (MEM_REQ && !MEM_ACK) begin
          PC_WE        = 1'b0;
          IF_ID_WE     = 1'b0;
          ID_EX_WE     = 1'b0;
          EX_MEM_WE    = 1'b0;
          MEM_WB_FLUSH = 1'b1;
          state_d      = HZ_MEM_WAIT;
        end else if (EX_BR_TAKEN) begin
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (load_use) begin
          PC_WE       = 1'b0;
          IF_ID_WE    = 1'b0;
          ID_EX_FLUSH = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        PC_WE     = 1'b0;
        IF_ID_WE  = 1'b0;
        ID_EX_WE  = 1'b0;
        EX_MEM_WE = 1'b0;
        if (MEM_ACK) begin
          state_d = HZ_RUN;
        end else begin
          MEM_WB_FLUSH = 1'b1;
          if (wait_q == WAIT_LAST) begin
            MEM_ERR = 1'b1;
            state_d = HZ_ERR_FLUSH;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      HZ_ERR_FLUSH: begin
        IF_ID_FLUSH  = 1'b1;
        ID_EX_FLUSH  = 1'b1;
        MEM_WB_FLUSH = 1'b1;
        state_d      = HZ_RUN;
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase

    // Reset holds the whole pipeline empty regardless of state
    if (!RST_N) begin
      PC_WE        = 1'b0;
      IF_ID_WE     = 1'b0;
      ID_EX_WE     = 1'b0;
      EX_MEM_WE    = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      MEM_WB_FLUSH = 1'b1;
      MEM_ERR      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= HZ_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  otter_sat_counter #(
    .W(PERF_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RST_N(RST_N),
    .INC  (!PC_WE),
    .CNT  (STALL_CNT)
  );

  otter_sat_counter #(
    .W(PERF_W)
  ) u_flush_cnt (
    .CLK  (CLK),
    .RST_N(RST_N),
    .INC  (IF_ID_FLUSH),
    .CNT  (FLUSH_CNT)
  );

endmodule
